// File: rtl/incr_seq_ctrl.sv
// Sequential controller around an external combinational incrementer.
// Provides start/stop/load control, a terminal limit, wrap or one-shot mode and an err flag.
module incr_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] inc_in,
  input  logic [WIDTH-1:0] inc_out,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_inc;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             busy_q, done_q;

  // Reference value used only to cross-check the external incrementer.
  assign count_inc = count_q + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          count_d = load_val;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (count_q == limit) begin
          if (wrap_en) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else begin
          count_d = inc_out;
          if (inc_out != count_inc) begin
            err_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (load) begin
          count_d = load_val;
          state_d = StIdle;
        end else if (start) begin
          count_d = '0;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  assign inc_in = count_q;
  assign count  = count_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

// File: tb/tb_incr_seq_ctrl.sv
// Directed bench for incr_seq_ctrl with a behavioural incrementer and an expectation queue.
module tb_incr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, load, wrap_en, fault;
  logic [3:0] load_val, limit, inc_in, inc_out, count;
  logic       busy, done, carry, err;

  typedef struct packed {
    logic [3:0] cnt;
    logic       bsy;
    logic       dn;
    logic       cy;
    logic       er;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  // Incrementer model; fault forces a wrong result.
  assign inc_out = fault ? 4'd0 : inc_in + 4'd1;

  incr_seq_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .wrap_en  (wrap_en),
    .inc_in   (inc_in),
    .inc_out  (inc_out),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .carry    (carry),
    .err      (err)
  );

  // Queue the expected post-edge state, advance one edge, then pop and compare.
  task automatic cyc(input logic [3:0] c, input logic b, input logic d, input logic cy,
                     input logic e, input string tag);
    exp_t exp_v;
    exp_t obs_v;
    string t;
    exp_q.push_back({c, b, d, cy, e});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = {count, busy, done, carry, err};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: count/busy/done/carry/err observed %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
             t, obs_v.cnt, obs_v.bsy, obs_v.dn, obs_v.cy, obs_v.er,
             exp_v.cnt, exp_v.bsy, exp_v.dn, exp_v.cy, exp_v.er);
    end
    checks++;
    assert (inc_in === exp_v.cnt) else begin
      errors++;
      $error("FAIL %s_inc_in: observed %h expected %h", t, inc_in, exp_v.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; wrap_en = 1'b0; fault = 1'b0;
    load_val = 4'd0; limit = 4'd0;
    #1;
    cyc(4'd0, 0, 0, 0, 0, "reset0");
    cyc(4'd0, 0, 0, 0, 0, "reset1");

    // Basic one-shot count to 5.
    rst = 1'b0; limit = 4'd5; wrap_en = 1'b0; start = 1'b1;
    cyc(4'd0, 1, 0, 0, 0, "basic_start");
    start = 1'b0;
    for (int i = 1; i <= 5; i++) cyc(4'(i), 1, 0, 0, 0, "basic_run");
    cyc(4'd5, 0, 1, 0, 0, "basic_done");
    cyc(4'd5, 0, 1, 0, 0, "basic_hold");

    // Restart from DONE, then reset mid-run at 3.
    start = 1'b1;
    cyc(4'd0, 1, 0, 0, 0, "restart");
    start = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(4'(i), 1, 0, 0, 0, "restart_run");
    rst = 1'b1;
    cyc(4'd0, 0, 0, 0, 0, "reset_midrun");
    rst = 1'b0;

    // Wrap mode with limit 3.
    limit = 4'd3; wrap_en = 1'b1; start = 1'b1;
    cyc(4'd0, 1, 0, 0, 0, "wrap_start");
    start = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(4'(i), 1, 0, 0, 0, "wrap_run");
    cyc(4'd0, 1, 0, 1, 0, "wrap_carry");
    for (int i = 1; i <= 3; i++) cyc(4'(i), 1, 0, 0, 0, "wrap_run2");
    cyc(4'd0, 1, 0, 1, 0, "wrap_carry2");
    stop = 1'b1;
    cyc(4'd0, 0, 0, 0, 0, "wrap_stop");
    stop = 1'b0;

    // Load 14, limit 1: rolls through 15 and 0 without carry.
    wrap_en = 1'b0; limit = 4'd1; load = 1'b1; load_val = 4'd14;
    cyc(4'd14, 0, 0, 0, 0, "load14");
    load = 1'b0; start = 1'b1;
    cyc(4'd14, 1, 0, 0, 0, "roll_start");
    start = 1'b0;
    cyc(4'd15, 1, 0, 0, 0, "roll_15");
    cyc(4'd0,  1, 0, 0, 0, "roll_0");
    cyc(4'd1,  1, 0, 0, 0, "roll_1");
    cyc(4'd1,  0, 1, 0, 0, "roll_done");

    // Stop beats load in RUN.
    limit = 4'd15; start = 1'b1;
    cyc(4'd0, 1, 0, 0, 0, "prio_start");
    start = 1'b0;
    for (int i = 1; i <= 4; i++) cyc(4'(i), 1, 0, 0, 0, "prio_run");
    stop = 1'b1; load = 1'b1; load_val = 4'd9;
    cyc(4'd4, 0, 0, 0, 0, "stop_over_load");
    stop = 1'b0; load_val = 4'd7;
    cyc(4'd7, 0, 0, 0, 0, "load7");
    load = 1'b0;

    // limit equal to start value: immediate terminal action.
    limit = 4'd7; start = 1'b1;
    cyc(4'd7, 1, 0, 0, 0, "eq_start");
    start = 1'b0;
    cyc(4'd7, 0, 1, 0, 0, "eq_done");
    load = 1'b1;
    cyc(4'd7, 0, 0, 0, 0, "done_load");
    load = 1'b0; wrap_en = 1'b1; start = 1'b1;
    cyc(4'd7, 1, 0, 0, 0, "eq_wrap_start");
    start = 1'b0;
    cyc(4'd0, 1, 0, 1, 0, "eq_wrap_carry");
    stop = 1'b1;
    cyc(4'd0, 0, 0, 0, 0, "eq_wrap_stop");
    stop = 1'b0;

    // Incrementer fault at count 2: err sticks until reset.
    wrap_en = 1'b0; limit = 4'd15; start = 1'b1;
    cyc(4'd0, 1, 0, 0, 0, "fault_start");
    start = 1'b0;
    cyc(4'd1, 1, 0, 0, 0, "fault_run1");
    cyc(4'd2, 1, 0, 0, 0, "fault_run2");
    fault = 1'b1;
    cyc(4'd0, 1, 0, 0, 1, "fault_hit");
    fault = 1'b0;
    cyc(4'd1, 1, 0, 0, 1, "err_sticky1");
    cyc(4'd2, 1, 0, 0, 1, "err_sticky2");
    stop = 1'b1;
    cyc(4'd2, 0, 0, 0, 1, "err_idle");
    stop = 1'b0; rst = 1'b1;
    cyc(4'd0, 0, 0, 0, 0, "err_reset");
    rst = 1'b0;
    cyc(4'd0, 0, 0, 0, 0, "idle_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
